// File: rtl/knapsack_pkg.sv
// Shared definitions for the knapsack search block: default sizes, the sum-width
// derivation, the controller states and the item record.
package knapsack_pkg;

  localparam int N_ITEMS_DEF = 5;
  localparam int VAL_W_DEF   = 8;
  localparam int WT_W_DEF    = 8;

  function automatic int calc_sum_w(input int val_w, input int n_items);
    return val_w + $clog2(n_items) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [VAL_W_DEF-1:0] value;
    logic [WT_W_DEF-1:0]  weight;
  } item_t;

endpackage

// File: rtl/knapsack_eval.sv
// Combinational evaluation of one selection mask: totals and capacity feasibility.
// Shared with the downstream checker so both agree on what a selection is worth.
module knapsack_eval
  import knapsack_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int WT_W    = WT_W_DEF,
  localparam int SUM_W  = calc_sum_w(VAL_W, N_ITEMS)
) (
  input  logic [N_ITEMS-1:0]            mask_i,
  input  logic [N_ITEMS-1:0][VAL_W-1:0] values_i,
  input  logic [N_ITEMS-1:0][WT_W-1:0]  weights_i,
  input  logic [SUM_W-1:0]              capacity_i,
  output logic [SUM_W-1:0]              total_value_o,
  output logic [SUM_W-1:0]              total_weight_o,
  output logic                          feasible_o
);

  // Sum the value and weight of every selected item
  always_comb begin
    total_value_o  = '0;
    total_weight_o = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      total_value_o  = total_value_o  + (mask_i[i] ? SUM_W'(values_i[i])  : {SUM_W{1'b0}});
      total_weight_o = total_weight_o + (mask_i[i] ? SUM_W'(weights_i[i]) : {SUM_W{1'b0}});
    end
    feasible_o = (total_weight_o <= capacity_i);
  end

endmodule

// File: rtl/knapsack_search.sv
// Exhaustive 0-1 knapsack solver: one selection mask per cycle in ascending order,
// keeping the first best-valued feasible selection and answering value >= min_value.
module knapsack_search
  import knapsack_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEF,
  parameter int VAL_W   = VAL_W_DEF,
  parameter int WT_W    = WT_W_DEF,
  localparam int SUM_W  = calc_sum_w(VAL_W, N_ITEMS),
  localparam int IDX_W  = $clog2(N_ITEMS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [IDX_W-1:0]   load_idx,
  input  logic [VAL_W-1:0]   load_value,
  input  logic [WT_W-1:0]    load_weight,
  input  logic               start,
  input  logic [SUM_W-1:0]   capacity,
  input  logic [SUM_W-1:0]   min_value,
  output logic               busy,
  output logic               done,
  output logic [N_ITEMS-1:0] best_mask,
  output logic [SUM_W-1:0]   best_value,
  output logic [SUM_W-1:0]   best_weight,
  output logic               found
);

  localparam logic [N_ITEMS:0] LAST_CNT = {1'b0, {N_ITEMS{1'b1}}};

  state_e                        state_q;
  logic [N_ITEMS:0]              cnt_q;
  logic [N_ITEMS-1:0][VAL_W-1:0] values_q;
  logic [N_ITEMS-1:0][WT_W-1:0]  weights_q;
  logic [SUM_W-1:0]              cap_q, min_q;
  logic [N_ITEMS-1:0]            best_mask_q, best_mask_d;
  logic [SUM_W-1:0]              best_value_q, best_value_d;
  logic [SUM_W-1:0]              best_weight_q, best_weight_d;
  logic                          busy_q, done_q, found_q;

  logic [SUM_W-1:0] tot_value_s, tot_weight_s;
  logic             feasible_s;
  logic             load_ok_s;

  knapsack_eval #(
    .N_ITEMS(N_ITEMS),
    .VAL_W  (VAL_W),
    .WT_W   (WT_W)
  ) u_eval (
    .mask_i        (cnt_q[N_ITEMS-1:0]),
    .values_i      (values_q),
    .weights_i     (weights_q),
    .capacity_i    (cap_q),
    .total_value_o (tot_value_s),
    .total_weight_o(tot_weight_s),
    .feasible_o    (feasible_s)
  );

  assign load_ok_s = load_valid && (state_q == IDLE) && (int'(load_idx) < N_ITEMS);

  // Strictly-greater replacement so ties keep the earlier, lower mask
  always_comb begin
    best_mask_d   = best_mask_q;
    best_value_d  = best_value_q;
    best_weight_d = best_weight_q;
    if (feasible_s && (tot_value_s > best_value_q)) begin
      best_mask_d   = cnt_q[N_ITEMS-1:0];
      best_value_d  = tot_value_s;
      best_weight_d = tot_weight_s;
    end else begin
      best_mask_d   = best_mask_q;
    end
  end

  // Controller, item table and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      values_q      <= '0;
      weights_q     <= '0;
      cap_q         <= '0;
      min_q         <= '0;
      best_mask_q   <= '0;
      best_value_q  <= '0;
      best_weight_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      found_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_ok_s) begin
            values_q[load_idx]  <= load_value;
            weights_q[load_idx] <= load_weight;
          end
          if (start) begin
            state_q       <= SCAN;
            cnt_q         <= '0;
            cap_q         <= capacity;
            min_q         <= min_value;
            best_mask_q   <= '0;
            best_value_q  <= '0;
            best_weight_q <= '0;
            found_q       <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        SCAN: begin
          best_mask_q   <= best_mask_d;
          best_value_q  <= best_value_d;
          best_weight_q <= best_weight_d;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            found_q <= (best_value_d >= min_q);
          end else begin
            cnt_q <= cnt_q + {{N_ITEMS{1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = busy_q;
  assign done        = done_q;
  assign best_mask   = best_mask_q;
  assign best_value  = best_value_q;
  assign best_weight = best_weight_q;
  assign found       = found_q;

endmodule

// File: tb/tb_knapsack_search.sv
// Self-checking bench for knapsack_search: directed scenarios plus random tables,
// compared against a brute-force subset model.
module tb_knapsack_search;
  import knapsack_pkg::*;

  localparam int N     = 5;
  localparam int SUM_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic             load_ready;
  logic [2:0]       load_idx = '0;
  logic [7:0]       load_value = '0;
  logic [7:0]       load_weight = '0;
  logic             start = 1'b0;
  logic [SUM_W-1:0] capacity = '0;
  logic [SUM_W-1:0] min_value = '0;
  logic             busy, done, found;
  logic [N-1:0]     best_mask;
  logic [SUM_W-1:0] best_value, best_weight;

  int n_checks = 0;
  int n_errors = 0;
  item_t tbl [N];

  knapsack_search dut (
    .clk(clk), .rst_n(rst_n),
    .load_valid(load_valid), .load_ready(load_ready), .load_idx(load_idx),
    .load_value(load_value), .load_weight(load_weight),
    .start(start), .capacity(capacity), .min_value(min_value),
    .busy(busy), .done(done), .best_mask(best_mask),
    .best_value(best_value), .best_weight(best_weight), .found(found)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Brute force over every subset; first strictly-better feasible subset wins
  task automatic ref_best(input int cap, output int bm, output int bv, output int bw);
    bm = 0; bv = 0; bw = 0;
    for (int m = 0; m < (1 << N); m++) begin
      int sv = 0;
      int sw = 0;
      for (int i = 0; i < N; i++)
        if (((m >> i) & 1) == 1) begin
          sv += int'(tbl[i].value);
          sw += int'(tbl[i].weight);
        end
      if (sw <= cap && sv > bv) begin
        bm = m; bv = sv; bw = sw;
      end
    end
  endtask

  task automatic load_item(input int idx, input int val, input int wt);
    @(negedge clk);
    check_eq("load_ready_idle", {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1; load_idx = 3'(idx); load_value = 8'(val); load_weight = 8'(wt);
    @(negedge clk);
    load_valid = 1'b0;
    if (idx < N) tbl[idx] = '{value: 8'(val), weight: 8'(wt)};
  endtask

  task automatic load_table(input int v0, v1, v2, v3, v4, input int w0, w1, w2, w3, w4);
    load_item(0, v0, w0); load_item(1, v1, w1); load_item(2, v2, w2);
    load_item(3, v3, w3); load_item(4, v4, w4);
  endtask

  // Runs one scan; optional load in the start cycle and optional mid-scan interference
  task automatic run_scan(input string tag, input int cap, input int minv,
                          input bit co_load, input int co_idx, input int co_val,
                          input int co_wt, input bit interfere);
    int k, bm, bv, bw, pulses;
    bit seen;
    @(negedge clk);
    start = 1'b1; capacity = SUM_W'(cap); min_value = SUM_W'(minv);
    if (co_load) begin
      load_valid = 1'b1; load_idx = 3'(co_idx); load_value = 8'(co_val); load_weight = 8'(co_wt);
      if (co_idx < N) tbl[co_idx] = '{value: 8'(co_val), weight: 8'(co_wt)};
    end
    ref_best(cap, bm, bv, bw);
    @(posedge clk); #1;
    start = 1'b0; load_valid = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    k = 1; seen = 1'b0; pulses = 0;
    while (!seen && k < 100) begin
      if (done) seen = 1'b1;
      else begin
        if (interfere && k == 5) begin
          check_eq({tag, "_ready_scan"}, {31'd0, load_ready}, 32'd0);
          start = 1'b1; load_valid = 1'b1; load_idx = 3'd0; load_value = 8'd99; load_weight = 8'd0;
        end else begin
          start = 1'b0; load_valid = 1'b0;
        end
        @(posedge clk); #1;
        k++;
      end
    end
    check_eq({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    check_eq({tag, "_latency"}, 32'(k), 32'd33);
    check_eq({tag, "_mask"}, 32'(best_mask), 32'(bm));
    check_eq({tag, "_value"}, 32'(best_value), 32'(bv));
    check_eq({tag, "_weight"}, 32'(best_weight), 32'(bw));
    check_eq({tag, "_found"}, {31'd0, found}, {31'd0, (bv >= minv)});
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check_eq({tag, "_extra_done"}, 32'(pulses), 32'd0);
    check_eq({tag, "_ready_after"}, {31'd0, load_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) tbl[i] = '0;
    #12;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_found", {31'd0, found}, 32'd0);
    check_eq("rst_mask", 32'(best_mask), 32'd0);
    check_eq("rst_value", 32'(best_value), 32'd0);
    check_eq("rst_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    run_scan("empty", 10, 0, 1'b0, 0, 0, 0, 1'b0);

    load_table(4, 2, 2, 1, 10, 12, 1, 2, 1, 4);
    run_scan("t1", 15, 15, 1'b0, 0, 0, 0, 1'b0);
    check_eq("t1_mask_const", 32'(best_mask), 32'b11110);
    check_eq("t1_value_const", 32'(best_value), 32'd15);
    check_eq("t1_weight_const", 32'(best_weight), 32'd8);
    check_eq("t1_found_const", {31'd0, found}, 32'd1);
    run_scan("t2", 16, 16, 1'b0, 0, 0, 0, 1'b0);
    check_eq("t2_found_const", {31'd0, found}, 32'd0);
    run_scan("t3a", 0, 0, 1'b0, 0, 0, 0, 1'b0);
    run_scan("t3b", 0, 1, 1'b0, 0, 0, 0, 1'b0);
    run_scan("t5", 15, 15, 1'b0, 0, 0, 0, 1'b1);
    check_eq("t5_mask_const", 32'(best_mask), 32'b11110);

    load_table(3, 3, 0, 0, 0, 5, 5, 0, 0, 0);
    run_scan("t4", 5, 3, 1'b0, 0, 0, 0, 1'b0);
    check_eq("t4_mask_const", 32'(best_mask), 32'd1);

    run_scan("co_load", 5, 50, 1'b1, 2, 200, 0, 1'b0);
    load_item(7, 255, 0);
    run_scan("bad_idx", 5, 0, 1'b0, 0, 0, 0, 1'b0);

    // Reset in the middle of a scan
    load_table(4, 2, 2, 1, 10, 12, 1, 2, 1, 4);
    @(negedge clk);
    start = 1'b1; capacity = 12'd15; min_value = 12'd15;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #2; rst_n = 1'b0; #1;
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_done", {31'd0, done}, 32'd0);
    check_eq("t6_mask", 32'(best_mask), 32'd0);
    check_eq("t6_value", 32'(best_value), 32'd0);
    check_eq("t6_weight", 32'(best_weight), 32'd0);
    check_eq("t6_found", {31'd0, found}, 32'd0);
    repeat (3) @(posedge clk);
    #1; check_eq("t6_done_hold", {31'd0, done}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < N; i++) tbl[i] = '0;
    check_eq("t6_ready", {31'd0, load_ready}, 32'd1);
    run_scan("t6_cleared", 100, 1, 1'b0, 0, 0, 0, 1'b0);
    load_table(4, 2, 2, 1, 10, 12, 1, 2, 1, 4);
    run_scan("t6_rerun", 15, 15, 1'b0, 0, 0, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < N; i++)
        load_item(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 120)));
      run_scan("rand", int'($urandom_range(0, 300)), int'($urandom_range(0, 700)),
               1'b0, 0, 0, 0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/knapsack_search.md
Name: knapsack_search

Overview:
Sequential 0-1 knapsack solver. It produces candidate item selections, where the existing checker consumes them. A host loads an item table (value and weight per item), then pulses start with a capacity and a minimum value. The block exhaustively enumerates all 2^N_ITEMS selections, one per cycle, and reports the best feasible selection plus a found flag, answering the decision question "value >= min_value within capacity".

Parameters:
N_ITEMS, 5, number of items; selection mask width
VAL_W, 8, width of one item value
WT_W, 8, width of one item weight
SUM_W, VAL_W+$clog2(N_ITEMS)+1, width of accumulated sums and limits (derived, not overridden)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  item-table write request
load_ready  out  1  high when in IDLE; a write occurs on load_valid&&load_ready
load_idx  in  $clog2(N_ITEMS)  item index; indices >= N_ITEMS are ignored
load_value  in  VAL_W  item value
load_weight  in  WT_W  item weight
start  in  1  one-cycle request; accepted only in IDLE
capacity  in  SUM_W  max total weight; latched on accepted start
min_value  in  SUM_W  decision threshold; latched on accepted start
busy  out  1  high while scanning
done  out  1  one-cycle pulse when results are valid
best_mask  out  N_ITEMS  bit i set means item i selected
best_value  out  SUM_W  value of best_mask
best_weight  out  SUM_W  weight of best_mask
found  out  1  best_value >= latched min_value

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, found=0, best_mask/value/weight=0, item table all zero, load_ready=1 after reset.
- FSM IDLE -> SCAN on start; SCAN -> DONE after mask 2^N_ITEMS-1 is evaluated; DONE -> IDLE unconditionally (1 cycle).
- Timing: start sampled in cycle 0; mask m evaluated in cycle m+1; busy high cycles 1..2^N_ITEMS; done high in cycle 2^N_ITEMS+1 only. Default N=5: done at cycle 33.
- Enumeration order is ascending binary, 0 to 2^N-1. The counter is N_ITEMS+1 bits so the terminal count does not wrap.
- Evaluation is combinational within the cycle: total_value = sum of value[i] for set bits, total_weight likewise, zero-extended to SUM_W. Overflow is impossible by construction.
- Feasible means total_weight <= capacity (inclusive).
- Update rule: on a feasible mask with total_value strictly greater than the running best, replace best. Ties keep the earlier (lower) mask.
- Running best is initialised on scan entry to mask 0, value 0, weight 0. Mask 0 is always feasible, so best_* is always defined.
- found is computed and registered with done. best_*/found hold from DONE until the next accepted start. best_* update live during SCAN and are meaningful only when done pulses.
- Load handshake: load_ready = (state==IDLE). Writes in other states are dropped, so the table is unchanged. A load and a start in the same IDLE cycle are both accepted, and the scan sees the new entry.
- start during SCAN/DONE is ignored (no queueing).
- Reset mid-scan aborts immediately to reset values, with no done pulse. The item table is cleared.

Decomposition:
- Shared package knapsack_pkg holds the N_ITEMS/VAL_W/WT_W defaults, the SUM_W derivation function, the state enum (IDLE, SCAN, DONE) and the item struct {value, weight}.
- One sub-module, knapsack_eval: purely combinational mask + item table + capacity -> total_value, total_weight, feasible. This is the same evaluation the checker performs, reusable by both.

Test Plan:
1. Load values {4,2,2,1,10}, weights {12,1,2,1,4}; capacity=15, min_value=15 -> done at cycle 33, best_mask=5'b11110, best_value=15, best_weight=8, found=1.
2. Same table, capacity=16, min_value=16 -> best_mask=5'b11110, value 15, found=0 (A+E=14 does not win).
3. capacity=0, min_value=0 -> best_mask=0, best_value=0, best_weight=0, found=1. With min_value=1 -> found=0.
4. Tie: values {3,3,0,0,0}, weights {5,5,0,0,0}, capacity=5 -> best_mask=5'b00001 (lower mask wins), value 3.
5. Pulse start and load_valid (idx 0, value 99) mid-scan -> load_ready=0, write dropped, start ignored, result identical to the prior scan, exactly one done pulse.
6. Deassert rst_n at cycle 10 of a scan -> outputs zero asynchronously, no done pulse. After release, load_ready=1, and a fresh load+start completes in 33 cycles.
